// File: rtl/sram_axi_bridge.sv
// Bridges the CPU's instruction-fetch and data sram-like request ports onto a
// single AXI3 master. At most one read and one write are in flight; data loads
// are held off while any write is pending, so read-after-write ordering needs no
// address comparison.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   inst_sram_*           fetch request port (read only)
//   data_sram_*           load/store request port
//   ar*/r*                AXI read address / read data channels
//   aw*/w*/b*             AXI write address / write data / write response channels
module sram_axi_bridge #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  // instruction port
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // data port
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  input  logic        rlast,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  output logic        wlast,
  input  logic        wready,
  // AXI write response
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {RIdle, RAr, RR} r_state_e;
  typedef enum logic [1:0] {WIdle, WAw, WB} w_state_e;

  r_state_e    r_state_q, r_state_d;
  w_state_e    w_state_q, w_state_d;

  logic [31:0] ar_addr_q, ar_addr_d;
  logic [3:0]  ar_id_q, ar_id_d;
  logic [2:0]  ar_size_q, ar_size_d;

  logic [31:0] aw_addr_q, aw_addr_d;
  logic [2:0]  aw_size_q, aw_size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;

  logic r_idle, w_idle;
  logic load_ok, store_ok, fetch_ok;

  // Single-beat bursts only; rlast carries no extra information.
  logic unused_rlast;
  assign unused_rlast = rlast;

  assign r_idle = (r_state_q == RIdle);
  assign w_idle = (w_state_q == WIdle);

  // Data accesses need both channels idle: loads wait out pending stores and
  // stores wait out pending reads, which keeps data-side ordering trivial.
  assign load_ok  = ~reset & data_sram_req & ~data_sram_wr & r_idle & w_idle;
  assign store_ok = ~reset & data_sram_req &  data_sram_wr & w_idle & r_idle;
  assign fetch_ok = ~reset & inst_sram_req & r_idle & ~(data_sram_req & ~data_sram_wr);

  assign inst_sram_addr_ok = fetch_ok;
  assign data_sram_addr_ok = load_ok | store_ok;

  // Read channel next-state
  always_comb begin
    r_state_d = r_state_q;
    ar_addr_d = ar_addr_q;
    ar_id_d   = ar_id_q;
    ar_size_d = ar_size_q;
    unique case (r_state_q)
      RIdle: begin
        if (load_ok) begin
          r_state_d = RAr;
          ar_addr_d = data_sram_addr;
          ar_id_d   = ID_DATA;
          ar_size_d = {1'b0, data_sram_size};
        end else if (fetch_ok) begin
          r_state_d = RAr;
          ar_addr_d = inst_sram_addr;
          ar_id_d   = ID_INST;
          ar_size_d = 3'd2;
        end
      end
      RAr:     if (arready) r_state_d = RR;
      RR:      if (rvalid)  r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  // Write channel next-state
  always_comb begin
    w_state_d = w_state_q;
    aw_addr_d = aw_addr_q;
    aw_size_d = aw_size_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    unique case (w_state_q)
      WIdle: begin
        if (store_ok) begin
          w_state_d = WAw;
          aw_addr_d = data_sram_addr;
          aw_size_d = {1'b0, data_sram_size};
          wdata_d   = data_sram_wdata;
          wstrb_d   = data_sram_wstrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end
      end
      WAw: begin
        // aw and w handshake independently; leave once neither is outstanding.
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        if (!awvalid_d && !wvalid_d) w_state_d = WB;
      end
      WB:      if (bvalid) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= RIdle;
      w_state_q <= WIdle;
      ar_addr_q <= '0;
      ar_id_q   <= '0;
      ar_size_q <= '0;
      aw_addr_q <= '0;
      aw_size_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      ar_addr_q <= ar_addr_d;
      ar_id_q   <= ar_id_d;
      ar_size_q <= ar_size_d;
      aw_addr_q <= aw_addr_d;
      aw_size_q <= aw_size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
    end
  end

  // arvalid is a decode of registered state, so it rises the cycle after accept.
  assign arvalid = (r_state_q == RAr);
  assign arid    = ar_id_q;
  assign araddr  = ar_addr_q;
  assign arsize  = ar_size_q;
  assign arlen   = 4'd0;
  assign arburst = 2'b01;
  assign rready  = (r_state_q == RR);

  assign awid    = ID_DATA;
  assign awaddr  = aw_addr_q;
  assign awsize  = aw_size_q;
  assign awlen   = 4'd0;
  assign awburst = 2'b01;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wvalid  = wvalid_q;
  assign wlast   = 1'b1;
  assign bready  = (w_state_q == WB);

  // Gated by reset so an abandoned transaction never reports completion.
  assign inst_sram_data_ok = ~reset & rvalid & rready & (rid == ID_INST);
  assign data_sram_data_ok = ~reset & ((rvalid & rready & (rid == ID_DATA)) | (bvalid & bready));
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed self-checking bench for sram_axi_bridge. The AXI slave side is driven
// cycle by cycle from each scenario task; inputs change 1ns after the rising edge
// and outputs are sampled 1ns later.
module tb_sram_axi_bridge;

  logic        clk, reset;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, arlen, rid, awid, awlen, wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, arready, rvalid, rlast, rready;
  logic        awvalid, awready, wvalid, wlast, wready, bvalid, bready;

  int total  = 0;
  int passed = 0;

  sram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    settle();
    total++; if (arvalid !== 1'b0) $display("FAIL reset_arvalid got %0b exp 0", arvalid); else passed++;
    total++; if (rready !== 1'b0) $display("FAIL reset_rready got %0b exp 0", rready); else passed++;
    total++; if ({awvalid, wvalid, bready} !== 3'b000)
      $display("FAIL reset_wchan got %b exp 000", {awvalid, wvalid, bready}); else passed++;
    total++; if ({inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok} !== 4'b0)
      $display("FAIL reset_ok got %b exp 0000",
               {inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok});
    else passed++;
    total++; if (araddr !== 32'h0) $display("FAIL reset_araddr got %h exp 0", araddr); else passed++;
    total++; if ({wlast, awid, arlen, arburst} !== {1'b1, 4'd1, 4'd0, 2'b01})
      $display("FAIL reset_consts got %b exp 1000100000001", {wlast, awid, arlen, arburst});
    else passed++;
  endtask

  task automatic test_fetch();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0000; arready = 1'b1;
    settle();
    total++; if (inst_sram_addr_ok !== 1'b1) $display("FAIL fetch_addr_ok got %0b exp 1", inst_sram_addr_ok); else passed++;
    tick();
    inst_sram_req = 1'b0;
    settle();
    total++; if ({arvalid, araddr, arsize, arid} !== {1'b1, 32'h1c00_0000, 3'd2, 4'd0})
      $display("FAIL fetch_ar got %0b %h %0d %0d exp 1 1c000000 2 0", arvalid, araddr, arsize, arid);
    else passed++;
    tick();
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h0280_0c0c;
    settle();
    total++; if ({rready, inst_sram_data_ok, data_sram_data_ok} !== 3'b110)
      $display("FAIL fetch_data_ok got %b exp 110", {rready, inst_sram_data_ok, data_sram_data_ok});
    else passed++;
    total++; if (inst_sram_rdata !== 32'h0280_0c0c)
      $display("FAIL fetch_rdata got %h exp 02800c0c", inst_sram_rdata); else passed++;
    tick();
    rvalid = 1'b0;
    settle();
    total++; if (rready !== 1'b0) $display("FAIL fetch_rready_drop got %0b exp 0", rready); else passed++;
  endtask

  task automatic test_load_priority();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0040;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_size = 2'd2;
    data_sram_addr = 32'h1c00_8004; arready = 1'b1;
    settle();
    total++; if ({data_sram_addr_ok, inst_sram_addr_ok} !== 2'b10)
      $display("FAIL prio_addr_ok got %b exp 10", {data_sram_addr_ok, inst_sram_addr_ok}); else passed++;
    tick();
    data_sram_req = 1'b0;
    settle();
    total++; if ({arvalid, arid, araddr, inst_sram_addr_ok} !== {1'b1, 4'd1, 32'h1c00_8004, 1'b0})
      $display("FAIL prio_load_ar got %0b %0d %h %0b exp 1 1 1c008004 0",
               arvalid, arid, araddr, inst_sram_addr_ok);
    else passed++;
    tick();
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h1234_5678;
    settle();
    total++; if ({data_sram_data_ok, inst_sram_data_ok, inst_sram_addr_ok} !== 3'b100)
      $display("FAIL prio_load_ok got %b exp 100",
               {data_sram_data_ok, inst_sram_data_ok, inst_sram_addr_ok});
    else passed++;
    total++; if (data_sram_rdata !== 32'h1234_5678)
      $display("FAIL prio_load_rdata got %h exp 12345678", data_sram_rdata); else passed++;
    tick();
    rvalid = 1'b0;
    settle();
    total++; if (inst_sram_addr_ok !== 1'b1)
      $display("FAIL prio_fetch_accept got %0b exp 1", inst_sram_addr_ok); else passed++;
    tick();
    inst_sram_req = 1'b0;
    settle();
    total++; if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'h1c00_0040})
      $display("FAIL prio_fetch_ar got %0b %0d %h exp 1 0 1c000040", arvalid, arid, araddr);
    else passed++;
    tick();
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h0000_0001;
    settle();
    total++; if (inst_sram_data_ok !== 1'b1)
      $display("FAIL prio_fetch_data_ok got %0b exp 1", inst_sram_data_ok); else passed++;
    tick();
    rvalid = 1'b0;
  endtask

  task automatic test_store();
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_size = 2'd2;
    data_sram_addr = 32'h1c00_8000; data_sram_wdata = 32'hdead_beef; data_sram_wstrb = 4'hf;
    awready = 1'b0; wready = 1'b1;
    settle();
    total++; if (data_sram_addr_ok !== 1'b1) $display("FAIL store_addr_ok got %0b exp 1", data_sram_addr_ok); else passed++;
    tick();
    data_sram_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      awready = (i == 4);
      settle();
      total++; if ({awvalid, wvalid, bready} !== {1'b1, i == 1, 1'b0})
        $display("FAIL store_cycle%0d got %b exp 1%0b0", i, {awvalid, wvalid, bready}, i == 1);
      else passed++;
      tick();
    end
    awready = 1'b0;
    settle();
    total++; if ({awaddr, wdata, wstrb, awsize} !== {32'h1c00_8000, 32'hdead_beef, 4'hf, 3'd2})
      $display("FAIL store_payload got %h %h %h %0d exp 1c008000 deadbeef f 2",
               awaddr, wdata, wstrb, awsize);
    else passed++;
    total++; if ({awvalid, wvalid, bready, data_sram_data_ok} !== 4'b0010)
      $display("FAIL store_wb got %b exp 0010", {awvalid, wvalid, bready, data_sram_data_ok}); else passed++;
    tick();
    bvalid = 1'b1;
    settle();
    total++; if (data_sram_data_ok !== 1'b1) $display("FAIL store_data_ok got %0b exp 1", data_sram_data_ok); else passed++;
    tick();
    bvalid = 1'b0;
    settle();
    total++; if (bready !== 1'b0) $display("FAIL store_bready_drop got %0b exp 0", bready); else passed++;
  endtask

  task automatic test_load_behind_store();
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h1c00_8010;
    awready = 1'b1; wready = 1'b1;
    tick();
    data_sram_wr = 1'b0; data_sram_addr = 32'h1c00_8010;
    settle();
    total++; if (data_sram_addr_ok !== 1'b0) $display("FAIL lbs_waw got %0b exp 0", data_sram_addr_ok); else passed++;
    tick();
    settle();
    total++; if ({bready, data_sram_addr_ok} !== 2'b10)
      $display("FAIL lbs_wb got %b exp 10", {bready, data_sram_addr_ok}); else passed++;
    tick();
    bvalid = 1'b1;
    settle();
    total++; if ({data_sram_data_ok, data_sram_addr_ok} !== 2'b10)
      $display("FAIL lbs_bresp got %b exp 10", {data_sram_data_ok, data_sram_addr_ok}); else passed++;
    tick();
    bvalid = 1'b0;
    settle();
    total++; if (data_sram_addr_ok !== 1'b1) $display("FAIL lbs_accept got %0b exp 1", data_sram_addr_ok); else passed++;
    tick();
    data_sram_req = 1'b0; arready = 1'b1;
    settle();
    total++; if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h1c00_8010})
      $display("FAIL lbs_ar got %0b %0d %h exp 1 1 1c008010", arvalid, arid, araddr); else passed++;
    tick();
    rvalid = 1'b1; rid = 4'd1; rdata = 32'hcafe_f00d;
    settle();
    total++; if (data_sram_data_ok !== 1'b1) $display("FAIL lbs_load_ok got %0b exp 1", data_sram_data_ok); else passed++;
    tick();
    rvalid = 1'b0;
  endtask

  task automatic test_arready_stall();
    int oks = 0;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0010; arready = 1'b0;
    tick();
    inst_sram_req = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      rvalid = (i == 3); rid = 4'd0;  // stray rvalid outside R_R must be ignored
      settle();
      total++; if ({arvalid, arid, araddr, inst_sram_data_ok} !== {1'b1, 4'd0, 32'h1c00_0010, 1'b0})
        $display("FAIL stall_cycle%0d got %0b %0d %h %0b exp 1 0 1c000010 0",
                 i, arvalid, arid, araddr, inst_sram_data_ok);
      else passed++;
      tick();
    end
    rvalid = 1'b0; arready = 1'b1;
    settle();
    total++; if (arvalid !== 1'b1) $display("FAIL stall_release got %0b exp 1", arvalid); else passed++;
    tick();
    for (int i = 0; i < 3; i++) begin
      rvalid = (i == 0); rid = 4'd0; rdata = 32'h0000_00aa;
      settle();
      if (inst_sram_data_ok === 1'b1) oks++;
      tick();
    end
    rvalid = 1'b0;
    total++; if (oks !== 1) $display("FAIL stall_data_ok_count got %0d exp 1", oks); else passed++;
  endtask

  task automatic test_reset_in_r();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0020; arready = 1'b1;
    tick();
    inst_sram_req = 1'b0;
    tick();
    reset = 1'b1;
    settle();
    total++; if (rready !== 1'b1) $display("FAIL rst_in_rr got %0b exp 1", rready); else passed++;
    tick();
    reset = 1'b0;
    settle();
    total++; if ({rready, arvalid} !== 2'b00)
      $display("FAIL rst_after got %b exp 00", {rready, arvalid}); else passed++;
    rvalid = 1'b1; rid = 4'd0;
    settle();
    total++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00)
      $display("FAIL rst_stray_rvalid got %b exp 00", {inst_sram_data_ok, data_sram_data_ok}); else passed++;
    tick();
    rvalid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    inst_sram_req = 1'b0; inst_sram_addr = '0;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = '0;
    data_sram_wstrb = '0; data_sram_addr = '0; data_sram_wdata = '0;
    arready = 1'b0; rid = '0; rdata = '0; rvalid = 1'b0; rlast = 1'b1;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    test_reset();
    test_fetch();
    test_load_priority();
    test_store();
    test_load_behind_store();
    test_arready_stall();
    test_reset_in_r();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
Converts the CPU's two sram-like request ports (instruction fetch, data load/store) into one AXI3 master port. It sits directly downstream of the pipeline top, replacing the direct SRAM connection.
- Allows at most one outstanding read and one outstanding write.
- Orders data reads behind pending writes, so no address comparison is needed.

Parameters:
ID_INST, 4'd0, arid used for instruction reads
ID_DATA, 4'd1, arid/awid used for data accesses

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_sram_req  in  1  fetch request (read only)
inst_sram_addr  in  32  fetch address
inst_sram_addr_ok  out  1  fetch request accepted this cycle
inst_sram_data_ok  out  1  fetch data valid this cycle
inst_sram_rdata  out  32  fetch data
data_sram_req  in  1  data request
data_sram_wr  in  1  1=store, 0=load
data_sram_size  in  2  0=byte, 1=half, 2=word
data_sram_wstrb  in  4  store byte enables
data_sram_addr  in  32  data address
data_sram_wdata  in  32  store data
data_sram_addr_ok  out  1  data request accepted this cycle
data_sram_data_ok  out  1  load data valid, or store complete, this cycle
data_sram_rdata  out  32  load data
arid/araddr/arsize/arvalid  out  4/32/3/1  AXI read address channel
arready  in  1  AXI read address ready
rid/rdata/rvalid/rlast  in  4/32/1/1  AXI read data channel
rready  out  1  AXI read data ready
awid/awaddr/awsize/awvalid  out  4/32/3/1  AXI write address channel
awready  in  1  AXI write address ready
wdata/wstrb/wvalid/wlast  out  32/4/1/1  AXI write data channel
wready  in  1  AXI write data ready
bvalid  in  1  AXI write response valid
bready  out  1  AXI write response ready

Behaviour:
- Constant outputs:
  - arlen/awlen = 0, burst INCR, single beat.
  - wlast = 1.
  - awid = ID_DATA.
  - lock, cache and prot fields are tied to 0 at the integration level.
- Read FSM states: R_IDLE, R_AR, R_R.
  - R_IDLE -> R_AR on acceptance of a read.
  - R_AR -> R_R on arvalid & arready.
  - R_R -> R_IDLE on rvalid & rready.
- Write FSM states: W_IDLE, W_AW, W_B.
  - W_IDLE -> W_AW on acceptance of a store.
  - W_AW -> W_B once both the aw and w handshakes have completed (in any order, or in the same cycle).
  - W_B -> W_IDLE on bvalid & bready.
- Acceptance is combinational, in the same cycle as req:
  - data_addr_ok (load) = data_req & ~wr & R_IDLE & W_IDLE.
  - data_addr_ok (store) = data_req & wr & W_IDLE & R_IDLE.
  - inst_addr_ok = inst_req & R_IDLE & ~(data_req & ~wr).
  - Data loads win over fetches in the same cycle.
- On acceptance, the bridge latches:
  - address, arid (ID_INST or ID_DATA), and arsize (2 for fetch, data_sram_size for load);
  - for stores, additionally awsize, wdata and wstrb.
- arvalid is registered: it goes high the cycle after acceptance and holds with stable araddr/arid/arsize until arready.
- rready = 1 only in R_R.
- Write channel valids:
  - awvalid and wvalid rise together the cycle after acceptance.
  - Each drops independently the cycle after its own handshake.
- bready = 1 only in W_B.
- Response routing:
  - inst_data_ok = rvalid & rready & (rid == ID_INST).
  - data_data_ok = (rvalid & rready & rid == ID_DATA) | (bvalid & bready).
  - The two data_ok sources never coincide, because reads and writes are mutually exclusive.
  - rdata passes through combinationally to both rdata outputs.
- Minimum read latency: accept in cycle 0, arvalid in cycle 1, data_ok in cycle 2 (arready and rvalid immediate).
- Reset values: both FSMs idle; all valids, rready, bready, addr_ok and data_ok = 0; latched registers = 0.
- Reset mid-transaction abandons the transaction: no data_ok is produced for it, and the FSMs are idle the next cycle.
- A held req that is not accepted stays pending with no side effect.
- rvalid or bvalid arriving outside R_R/W_B is ignored.

Test Plan:
- Fetch: inst_req, addr 0x1c000000, arready=1, rvalid in cycle 2 with rid=0 and rdata 0x02800c0c.
  -> addr_ok in cycle 0; arvalid in cycle 1 with araddr 0x1c000000, arsize 2; inst_data_ok and rdata 0x02800c0c in cycle 2.
- Simultaneous inst_req and load at 0x1c008004.
  -> data_addr_ok=1, inst_addr_ok=0.
  -> Fetch is accepted in the first cycle back in R_IDLE after data_data_ok.
- Store: addr 0x1c008000, wdata 0xdeadbeef, wstrb 0xf, wready=1, awready low for 3 cycles.
  -> wvalid high for 1 cycle; awvalid high for 4 cycles; then bready; data_data_ok on bvalid.
- Load issued while a store is in W_B.
  -> data_addr_ok stays 0 until the cycle after the bvalid handshake.
- arready held low for 5 cycles.
  -> arvalid, araddr and arid stay stable; exactly one inst_data_ok follows.
- Reset asserted in R_R.
  -> rready=0 and arvalid=0 the next cycle; a subsequent rvalid produces no data_ok.
